huffman_code_gen: RTL

- Consumes the merge record produced by the Huffman tree builder: ten 4-bit node ids, two per merge step, steps 0..4.
- Walks that record root-first, one step per clock, and assigns every node its code prefix and length.
- Presents the final code and mask for the six symbols to the output/encode stage.
- Sits directly downstream of the tree builder; its input is the builder's tree_0_k/tree_1_k ports plus tree_done.

---
 rtl/huffman_code_gen_pkg.sv | 20 ++
 rtl/huffman_node_table.sv | 66 ++++++
 rtl/huffman_code_gen.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/huffman_code_gen_pkg.sv
// Shared constants and FSM state type for the Huffman code generator.
// Node ids: leaves 0..5 are symbols 1..6, internal nodes 6..9 come from merge steps 0..3.
package huffman_code_gen_pkg;

    localparam int NUM_SYM       = 6;
    localparam int NUM_STEP      = 5;
    localparam int LEAF_MAX      = 5;
    localparam int INTERNAL_BASE = 6;
    localparam int MAX_DEPTH     = 5;
    localparam int NUM_NODE      = 10;
    localparam int LEN_W         = 3;
    localparam int ID_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/huffman_node_table.sv
// Ten-entry code/length register file: two synchronous write ports (bit-0 and
// bit-1 child), one asynchronous parent read port and a flat readout of the leaves.
module huffman_node_table
    import huffman_code_gen_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_we,
    input  logic [ID_W-1:0]                i_waddr0,
    input  logic [MAX_DEPTH-1:0]           i_wcode0,
    input  logic [LEN_W-1:0]               i_wlen0,
    input  logic [ID_W-1:0]                i_waddr1,
    input  logic [MAX_DEPTH-1:0]           i_wcode1,
    input  logic [LEN_W-1:0]               i_wlen1,
    input  logic [ID_W-1:0]                i_raddr,
    output logic [MAX_DEPTH-1:0]           o_rcode,
    output logic [LEN_W-1:0]               o_rlen,
    output logic [NUM_SYM*MAX_DEPTH-1:0]   o_leaf_code,
    output logic [NUM_SYM*LEN_W-1:0]       o_leaf_len
);

    logic [MAX_DEPTH-1:0] r_code [NUM_NODE];
    logic [LEN_W-1:0]     r_len  [NUM_NODE];

    // Out-of-range write addresses simply hit no entry; the top flags them as errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_NODE; i++) begin
                r_code[i] <= '0;
                r_len[i]  <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < NUM_NODE; i++) begin
                if (i_waddr0 == ID_W'(i)) begin
                    r_code[i] <= i_wcode0;
                    r_len[i]  <= i_wlen0;
                end
                if (i_waddr1 == ID_W'(i)) begin
                    r_code[i] <= i_wcode1;
                    r_len[i]  <= i_wlen1;
                end
            end
        end
    end

    always_comb begin
        o_rcode = '0;
        o_rlen  = '0;
        for (int i = 0; i < NUM_NODE; i++) begin
            if (i_raddr == ID_W'(i)) begin
                o_rcode = r_code[i];
                o_rlen  = r_len[i];
            end
        end
    end

    always_comb begin
        o_leaf_code = '0;
        o_leaf_len  = '0;
        for (int i = 0; i < NUM_SYM; i++) begin
            o_leaf_code[i*MAX_DEPTH +: MAX_DEPTH] = r_code[i];
            o_leaf_len[i*LEN_W +: LEN_W]          = r_len[i];
        end
    end

endmodule

// File: rtl/huffman_code_gen.sv
// Walks the tree builder's merge record root-first, one step per clock, and
// presents the resulting per-symbol code and mask once the walk completes.
module huffman_code_gen
    import huffman_code_gen_pkg::*;
#(
    parameter int CODE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tree_done,
    input  logic [3:0]        tree_0_0,
    input  logic [3:0]        tree_0_1,
    input  logic [3:0]        tree_0_2,
    input  logic [3:0]        tree_0_3,
    input  logic [3:0]        tree_0_4,
    input  logic [3:0]        tree_1_0,
    input  logic [3:0]        tree_1_1,
    input  logic [3:0]        tree_1_2,
    input  logic [3:0]        tree_1_3,
    input  logic [3:0]        tree_1_4,
    output logic [CODE_W-1:0] HC1,
    output logic [CODE_W-1:0] HC2,
    output logic [CODE_W-1:0] HC3,
    output logic [CODE_W-1:0] HC4,
    output logic [CODE_W-1:0] HC5,
    output logic [CODE_W-1:0] HC6,
    output logic [CODE_W-1:0] M1,
    output logic [CODE_W-1:0] M2,
    output logic [CODE_W-1:0] M3,
    output logic [CODE_W-1:0] M4,
    output logic [CODE_W-1:0] M5,
    output logic [CODE_W-1:0] M6,
    output logic              code_valid,
    output logic              tree_err
);

    function automatic logic [CODE_W-1:0] len_to_mask(input logic [LEN_W-1:0] len);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int i = 0; i < CODE_W; i++) begin
            if (i < int'(len)) m[i] = 1'b1;
        end
        return m;
    endfunction

    state_t                       r_state, w_state_next;
    logic [2:0]                   r_step;
    logic [NUM_SYM-1:0]           r_assigned;
    logic                         r_err;
    logic                         r_valid;

    logic                         w_we;
    logic                         w_root;
    logic [ID_W-1:0]              w_id0, w_id1, w_paddr, w_limit;
    logic [MAX_DEPTH-1:0]         w_pcode, w_code0, w_code1;
    logic [LEN_W-1:0]             w_plen, w_clen;
    logic [NUM_SYM-1:0]           w_hit0, w_hit1, w_assigned_next;
    logic                         w_step_err;
    logic [NUM_SYM*MAX_DEPTH-1:0] w_leaf_code;
    logic [NUM_SYM*LEN_W-1:0]     w_leaf_len;
    logic [CODE_W-1:0]            w_hc [NUM_SYM];
    logic [CODE_W-1:0]            w_m  [NUM_SYM];

    always_comb begin
        w_id0 = tree_0_4;
        w_id1 = tree_1_4;
        case (r_step)
            3'd0:    begin w_id0 = tree_0_0; w_id1 = tree_1_0; end
            3'd1:    begin w_id0 = tree_0_1; w_id1 = tree_1_1; end
            3'd2:    begin w_id0 = tree_0_2; w_id1 = tree_1_2; end
            3'd3:    begin w_id0 = tree_0_3; w_id1 = tree_1_3; end
            default: begin w_id0 = tree_0_4; w_id1 = tree_1_4; end
        endcase
    end

    // Root step seeds depth-1 codes; every later step extends its parent's code.
    assign w_root  = (r_step == 3'd4);
    assign w_paddr = ID_W'(INTERNAL_BASE) + {1'b0, r_step};
    assign w_code0 = w_root ? '0   : {w_pcode[MAX_DEPTH-2:0], 1'b0};
    assign w_code1 = w_root ? 5'd1 : {w_pcode[MAX_DEPTH-2:0], 1'b1};
    assign w_clen  = w_root ? 3'd1 : w_plen + 3'd1;
    assign w_limit = w_root ? ID_W'(NUM_NODE - 1) : ID_W'(LEAF_MAX) + {1'b0, r_step};

    always_comb begin
        w_hit0 = '0;
        w_hit1 = '0;
        for (int i = 0; i < NUM_SYM; i++) begin
            w_hit0[i] = (w_id0 == ID_W'(i));
            w_hit1[i] = (w_id1 == ID_W'(i));
        end
        w_assigned_next = r_assigned | w_hit0 | w_hit1;
        w_step_err = (w_id0 > w_limit) || (w_id1 > w_limit) || (w_id0 == w_id1) ||
                     (|(r_assigned & (w_hit0 | w_hit1))) ||
                     ((r_step == 3'd0) && (w_assigned_next != '1));
    end

    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        case (r_state)
            ST_IDLE: if (tree_done) w_state_next = ST_WALK;
            ST_WALK: begin
                w_we = 1'b1;
                if (r_step == 3'd0) w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_assigned <= '0;
            r_err      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && tree_done) r_step <= 3'd4;
            if (w_we) begin
                r_step     <= r_step - 3'd1;
                r_assigned <= w_assigned_next;
                r_err      <= r_err | w_step_err;
                if (r_step == 3'd0) r_valid <= 1'b1;
            end
        end
    end

    huffman_node_table u_table (
        .clk         (clk),
        .reset       (reset),
        .i_we        (w_we),
        .i_waddr0    (w_id0),
        .i_wcode0    (w_code0),
        .i_wlen0     (w_clen),
        .i_waddr1    (w_id1),
        .i_wcode1    (w_code1),
        .i_wlen1     (w_clen),
        .i_raddr     (w_paddr),
        .o_rcode     (w_pcode),
        .o_rlen      (w_plen),
        .o_leaf_code (w_leaf_code),
        .o_leaf_len  (w_leaf_len)
    );

    // Table is frozen after the walk, so outputs are a pure function of registers.
    always_comb begin
        for (int i = 0; i < NUM_SYM; i++) begin
            w_hc[i] = '0;
            w_m[i]  = '0;
            if (r_valid && !r_err) begin
                w_hc[i] = CODE_W'(w_leaf_code[i*MAX_DEPTH +: MAX_DEPTH]);
                w_m[i]  = len_to_mask(w_leaf_len[i*LEN_W +: LEN_W]);
            end
        end
    end

    assign HC1 = w_hc[0];
    assign HC2 = w_hc[1];
    assign HC3 = w_hc[2];
    assign HC4 = w_hc[3];
    assign HC5 = w_hc[4];
    assign HC6 = w_hc[5];
    assign M1  = w_m[0];
    assign M2  = w_m[1];
    assign M3  = w_m[2];
    assign M4  = w_m[3];
    assign M5  = w_m[4];
    assign M6  = w_m[5];

    assign code_valid = r_valid;
    assign tree_err   = r_valid & r_err;

endmodule
